// File: rtl/b_field_uart_rx.sv
// UART receiver for field-measurement packets: sync byte, 4 data bytes (LE), XOR checksum.
// Publishes b_field/b_start two cycles after the checksum stop-bit sample; keeps frame/error counters.
module b_field_uart_rx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          TIMEOUT_BITS = 32,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        rx,
    output logic [31:0] b_field,
    output logic        b_start,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    localparam int HALF_BIT    = CLKS_PER_BIT / 2;
    localparam int CW          = $clog2(CLKS_PER_BIT);
    localparam int TIMEOUT_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GW          = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HUNT, P_D0, P_D1, P_D2, P_D3, P_CHK} p_state_t;

    logic            rx_meta_q, rxs_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            wait_high_q, wait_high_d;
    logic            byte_vld_q, byte_vld_d;
    logic [7:0]      byte_dat_q, byte_dat_d;
    logic            fe_q, fe_d;

    p_state_t        p_state_q, p_state_d;
    logic [31:0]     data_q, data_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [31:0]     b_field_q, b_field_d;
    logic            b_start_q, b_start_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            half_tick, bit_tick;
    logic            timeout, abort, chk_ok, pkt_good, pkt_err;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rx_state_q  <= RX_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            wait_high_q <= 1'b0;
            byte_vld_q  <= 1'b0;
            byte_dat_q  <= '0;
            fe_q        <= 1'b0;
            p_state_q   <= P_HUNT;
            data_q      <= '0;
            gap_cnt_q   <= '0;
            b_field_q   <= '0;
            b_start_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wait_high_q <= wait_high_d;
            byte_vld_q  <= byte_vld_d;
            byte_dat_q  <= byte_dat_d;
            fe_q        <= fe_d;
            p_state_q   <= p_state_d;
            data_q      <= data_d;
            gap_cnt_q   <= gap_cnt_d;
            b_field_q   <= b_field_d;
            b_start_q   <= b_start_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign half_tick = (bit_cnt_q == CW'(HALF_BIT - 1));
    assign bit_tick  = (bit_cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (!wait_high_q && !rxs_q) rx_state_d = RX_START;
            RX_START: if (half_tick) rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (bit_tick) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // Every sample point restarts the bit counter, so data bits land one bit time apart from mid-start.
    always_comb begin
        bit_cnt_d   = bit_cnt_q + CW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        wait_high_d = wait_high_q;
        byte_vld_d  = 1'b0;
        byte_dat_d  = byte_dat_q;
        fe_d        = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                bit_cnt_d = '0;
                if (wait_high_q && rxs_q) wait_high_d = 1'b0;
            end
            RX_START: begin
                if (half_tick) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                end
            end
            RX_DATA: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    if (rxs_q) begin
                        byte_vld_d = 1'b1;
                        byte_dat_d = shift_q;
                    end else begin
                        fe_d        = 1'b1;
                        wait_high_d = 1'b1;
                    end
                end
            end
            default: bit_cnt_d = '0;
        endcase
    end

    assign timeout = (p_state_q != P_HUNT) && !byte_vld_q && (gap_cnt_q == GW'(TIMEOUT_CYC - 1));
    assign abort   = (p_state_q != P_HUNT) && (fe_q || timeout);
    assign chk_ok  = (byte_dat_q == (data_q[7:0] ^ data_q[15:8] ^ data_q[23:16] ^ data_q[31:24]));

    always_comb begin
        p_state_d = p_state_q;
        if (abort) begin
            p_state_d = P_HUNT;
        end else if (byte_vld_q) begin
            case (p_state_q)
                P_HUNT:  if (byte_dat_q == SYNC_BYTE) p_state_d = P_D0;
                P_D0:    p_state_d = P_D1;
                P_D1:    p_state_d = P_D2;
                P_D2:    p_state_d = P_D3;
                P_D3:    p_state_d = P_CHK;
                default: p_state_d = P_HUNT;
            endcase
        end
    end

    // Data bytes shift in from the top, so d0 ends up in the low byte after four captures.
    always_comb begin
        data_d   = data_q;
        pkt_good = 1'b0;
        pkt_err  = abort;
        if (!abort && byte_vld_q) begin
            case (p_state_q)
                P_D0, P_D1, P_D2, P_D3: data_d = {byte_dat_q, data_q[31:8]};
                P_CHK: begin
                    pkt_good = chk_ok;
                    pkt_err  = !chk_ok;
                end
                default: data_d = data_q;
            endcase
        end
        gap_cnt_d   = (p_state_q == P_HUNT || byte_vld_q) ? '0 : gap_cnt_q + GW'(1);
        b_field_d   = pkt_good ? data_q : b_field_q;
        b_start_d   = pkt_good;
        frame_cnt_d = frame_cnt_q + {15'd0, pkt_good};
        err_cnt_d   = (pkt_err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    assign b_field   = b_field_q;
    assign b_start   = b_start_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (p_state_q != P_HUNT);

endmodule

// File: tb/tb_b_field_uart_rx.sv
// Bench for b_field_uart_rx: serial stimulus at 8 clocks/bit against a packet-level reference model.
module tb_b_field_uart_rx;

    localparam int         CPB  = 8;
    localparam int         TOB  = 32;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        rx;
    logic [31:0] b_field;
    logic        b_start;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;

    logic [31:0] exp_field;
    int          exp_frames;
    int          exp_err;
    int          exp_strobes;
    int          m_pos;
    logic [7:0]  m_d [4];

    b_field_uart_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB), .SYNC_BYTE(SYNC)) dut (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .rx        (rx),
        .b_field   (b_field),
        .b_start   (b_start),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) if (b_start === 1'b1) strobe_cnt++;

    task automatic model_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic model_abort();
        if (m_pos != 0) begin
            model_err();
            m_pos = 0;
        end
    endtask

    task automatic model_clear();
        exp_field  = 32'h0;
        exp_frames = 0;
        exp_err    = 0;
        m_pos      = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_pos == 0) begin
            if (b == SYNC) m_pos = 1;
        end else if (m_pos <= 4) begin
            m_d[m_pos-1] = b;
            m_pos++;
        end else begin
            if (b == (m_d[0] ^ m_d[1] ^ m_d[2] ^ m_d[3])) begin
                exp_field = {m_d[3], m_d[2], m_d[1], m_d[0]};
                exp_frames++;
                exp_strobes++;
            end else begin
                model_err();
            end
            m_pos = 0;
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge sys_clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        repeat (CPB) @(negedge sys_clk);
        if (bad_stop) begin
            idle_bits(2);
            model_abort();
        end else begin
            model_byte(b);
        end
    endtask

    task automatic send_pkt(input logic [31:0] d, input logic [7:0] chk_flip, input int max_gap);
        logic [7:0] pb [6];
        pb[0] = SYNC;
        pb[1] = d[7:0];
        pb[2] = d[15:8];
        pb[3] = d[23:16];
        pb[4] = d[31:24];
        pb[5] = d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24] ^ chk_flip;
        for (int i = 0; i < 6; i++) begin
            send_byte(pb[i], 1'b0);
            if (i < 5) idle_bits($urandom_range(0, max_gap));
        end
    endtask

    task automatic test_reset();
        sys_reset = 1'b1;
        rx = 1'b1;
        model_clear();
        repeat (3) @(negedge sys_clk);
        total++; if (b_field !== 32'h0) begin bad++; $display("FAIL reset_b_field: got %h expected 0", b_field); end
        total++; if (b_start !== 1'b0) begin bad++; $display("FAIL reset_b_start: got %b expected 0", b_start); end
        total++; if (frame_cnt !== 16'h0) begin bad++; $display("FAIL reset_frame_cnt: got %h expected 0", frame_cnt); end
        total++; if (err_cnt !== 8'h0) begin bad++; $display("FAIL reset_err_cnt: got %h expected 0", err_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        sys_reset = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_good();
        send_pkt(32'h12345678, 8'h00, 0);
        total++; if (b_start !== 1'b1) begin bad++; $display("FAIL good_strobe_timing: got %b expected 1", b_start); end
        total++; if (b_field !== exp_field) begin bad++; $display("FAIL good_field: got %h expected %h", b_field, exp_field); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_busy_fall: got %b expected 0", busy); end
        @(negedge sys_clk);
        total++; if (b_start !== 1'b0) begin bad++; $display("FAIL good_strobe_width: got %b expected 0", b_start); end
        total++; if (frame_cnt !== exp_frames[15:0]) begin bad++; $display("FAIL good_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
        total++; if (err_cnt !== exp_err[7:0]) begin bad++; $display("FAIL good_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
        idle_bits(1);
    endtask

    task automatic test_bad_checksum();
        send_pkt(32'h12345678, 8'h01, 1);
        idle_bits(2);
        total++; if (b_field !== exp_field) begin bad++; $display("FAIL badchk_field_hold: got %h expected %h", b_field, exp_field); end
        total++; if (err_cnt !== exp_err[7:0]) begin bad++; $display("FAIL badchk_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
        total++; if (strobe_cnt !== exp_strobes) begin bad++; $display("FAIL badchk_strobes: got %0d expected %0d", strobe_cnt, exp_strobes); end
        send_pkt(32'hCAFEF00D, 8'h00, 1);
        idle_bits(1);
        total++; if (b_field !== exp_field) begin bad++; $display("FAIL badchk_recover_field: got %h expected %h", b_field, exp_field); end
        total++; if (frame_cnt !== exp_frames[15:0]) begin bad++; $display("FAIL badchk_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_embedded_sync();
        logic [7:0] seq [8];
        seq = '{8'h00, 8'hFF, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5};
        for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b0);
        idle_bits(1);
        total++; if (b_field !== exp_field) begin bad++; $display("FAIL embsync_field: got %h expected %h", b_field, exp_field); end
        total++; if (strobe_cnt !== exp_strobes) begin bad++; $display("FAIL embsync_strobes: got %0d expected %0d", strobe_cnt, exp_strobes); end
    endtask

    task automatic test_framing();
        send_byte(SYNC, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h77, 1'b1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fe_busy: got %b expected 0", busy); end
        total++; if (err_cnt !== exp_err[7:0]) begin bad++; $display("FAIL fe_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
        // Short low pulse between bytes of an otherwise good packet must not disturb it.
        send_byte(SYNC, 1'b0);
        send_byte(8'h11, 1'b0);
        rx = 1'b0;
        repeat (4) @(negedge sys_clk);
        idle_bits(2);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1'b0);
        idle_bits(1);
        total++; if (b_field !== exp_field) begin bad++; $display("FAIL glitch_field: got %h expected %h", b_field, exp_field); end
        total++; if (err_cnt !== exp_err[7:0]) begin bad++; $display("FAIL glitch_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
    endtask

    task automatic test_timeout();
        send_byte(SYNC, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy_rise: got %b expected 1", busy); end
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        idle_bits(40);
        model_abort();
        total++; if (err_cnt !== exp_err[7:0]) begin bad++; $display("FAIL to_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_busy: got %b expected 0", busy); end
        send_pkt(32'h0BADBEEF, 8'h00, 2);
        idle_bits(1);
        total++; if (b_field !== exp_field) begin bad++; $display("FAIL to_recover_field: got %h expected %h", b_field, exp_field); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [7:0]  g;
        logic [7:0]  flip;
        for (int p = 0; p < 20; p++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                g = 8'($urandom_range(0, 255));
                if (g == SYNC) g = 8'h5A;
                send_byte(g, 1'b0);
                idle_bits($urandom_range(0, 1));
            end
            d = $urandom;
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_pkt(d, flip, 2);
            idle_bits($urandom_range(0, 2));
            total++; if (b_field !== exp_field) begin bad++; $display("FAIL rand_field[%0d]: got %h expected %h", p, b_field, exp_field); end
            total++; if (err_cnt !== exp_err[7:0]) begin bad++; $display("FAIL rand_err_cnt[%0d]: got %0d expected %0d", p, err_cnt, exp_err); end
        end
        idle_bits(1);
        total++; if (frame_cnt !== exp_frames[15:0]) begin bad++; $display("FAIL rand_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
        total++; if (strobe_cnt !== exp_strobes) begin bad++; $display("FAIL rand_strobes: got %0d expected %0d", strobe_cnt, exp_strobes); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] part;
        part = 8'h9C;
        send_byte(SYNC, 1'b0);
        send_byte(8'h78, 1'b0);
        rx = 1'b0;
        repeat (CPB) @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            rx = part[i];
            repeat (CPB) @(negedge sys_clk);
        end
        sys_reset = 1'b1;
        model_clear();
        #1;
        total++; if (b_field !== 32'h0) begin bad++; $display("FAIL rstmid_b_field: got %h expected 0", b_field); end
        total++; if (frame_cnt !== 16'h0) begin bad++; $display("FAIL rstmid_frame_cnt: got %h expected 0", frame_cnt); end
        total++; if (err_cnt !== 8'h0) begin bad++; $display("FAIL rstmid_err_cnt: got %h expected 0", err_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        rx = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_reset = 1'b0;
        idle_bits(2);
        send_pkt(32'h87654321, 8'h00, 1);
        idle_bits(1);
        total++; if (b_field !== exp_field) begin bad++; $display("FAIL rstmid_field: got %h expected %h", b_field, exp_field); end
        total++; if (frame_cnt !== exp_frames[15:0]) begin bad++; $display("FAIL rstmid_frames: got %0d expected %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 258; i++) begin
            send_byte(SYNC, 1'b0);
            send_byte(8'($urandom_range(0, 255)), 1'b1);
        end
        total++; if (err_cnt !== exp_err[7:0]) begin bad++; $display("FAIL sat_err_cnt: got %0d expected %0d", err_cnt, exp_err); end
        send_pkt(32'h00C0FFEE, 8'h01, 0);
        idle_bits(1);
        total++; if (err_cnt !== exp_err[7:0]) begin bad++; $display("FAIL sat_hold: got %0d expected %0d", err_cnt, exp_err); end
        send_pkt(32'h00C0FFEE, 8'h00, 0);
        idle_bits(1);
        total++; if (b_field !== exp_field) begin bad++; $display("FAIL sat_field: got %h expected %h", b_field, exp_field); end
    endtask

    initial begin
        exp_strobes = 0;
        test_reset();
        test_good();
        test_bad_checksum();
        test_embedded_sync();
        test_framing();
        test_timeout();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
